// File: rtl/ic_irq_controller.sv
// ---------------------------------------------------------------------------
// ic_irq_controller
//
// Interrupt controller stage feeding the processor model. Rising edges on
// the interrupt sources are latched as pending. A software mask hides sources
// from arbitration without discarding them. The lowest-index unmasked pending
// source is presented to the processor with a hold-until-ack handshake. A
// request that is never acknowledged is withdrawn after TIMEOUT cycles, the
// sticky timeout_err flag is set, and the source is retried later.
//
// Optional feature (build macro IC_DROP_CNT_EN):
//   defined   - drop_cnt counts coalesced edges, meaning edges that land on
//               bits that are already pending. It saturates at 8'hFF.
//   undefined - drop_cnt is tied to 0 and no counter logic is built.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous reset, active-high
//   irq_src      in   [NUM_IRQ] interrupt sources, synchronous, edge-sensitive
//   mask_wr      in   mask write strobe
//   mask_data    in   [NUM_IRQ] new mask value; a 1 disables that source
//   ack          in   one-cycle acknowledge from the processor
//   irq_out      out  interrupt request to the processor
//   irq_id_out   out  [ID_W] ID of the in-flight request
//   pending      out  [NUM_IRQ] pending register, shown without the mask
//   timeout_err  out  sticky flag, set when a request times out
//   drop_cnt     out  [8] coalesced-edge counter
// ---------------------------------------------------------------------------
module ic_irq_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               ack,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id_out,
    output logic [NUM_IRQ-1:0] pending,
    output logic               timeout_err,
    output logic [7:0]         drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // The last REQ cycle is the one in which the counter reads TIMEOUT-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t             state_q,       state_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q,     pending_d;
    logic [NUM_IRQ-1:0] mask_q,        mask_d;
    logic               irq_out_q,     irq_out_d;
    logic [ID_W-1:0]    irq_id_q,      irq_id_d;
    logic [7:0]         cnt_q,         cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] clr;
    logic [ID_W-1:0]    winner;

`ifdef IC_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Adds without wrapping. The counter holds at 8'hFF once it gets there.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
`endif

    always_comb begin
        edge_det = irq_src & ~prev_q;
        cand     = pending_q & ~mask_q;

        // Scan from the top down so that the lowest set index wins.
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = ID_W'(i);
            end
        end

        clr           = '0;
        state_d       = state_q;
        irq_out_d     = irq_out_q;
        irq_id_d      = irq_id_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        mask_d        = mask_wr ? mask_data : mask_q;

        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d   = REQ;
                    irq_out_d = 1'b1;
                    irq_id_d  = winner;
                    cnt_d     = '0;
                end
            end
            REQ: begin
                // The ack is checked first, so an ack in the final cycle
                // is not reported as a timeout.
                if (ack) begin
                    clr[irq_id_q] = 1'b1;
                    irq_out_d     = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    irq_out_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge is OR-ed in after the ack clear, so the new edge takes
        // priority and the bit stays pending.
        pending_d = (pending_q & ~clr) | edge_det;

`ifdef IC_DROP_CNT_EN
        drop_cnt_d = sat_add8(drop_cnt_q, 4'($countones(edge_det & pending_q)));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            pending_q     <= '0;
            mask_q        <= '0;
            irq_out_q     <= 1'b0;
            irq_id_q      <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`ifdef IC_DROP_CNT_EN
            drop_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            prev_q        <= irq_src;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            irq_out_q     <= irq_out_d;
            irq_id_q      <= irq_id_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`ifdef IC_DROP_CNT_EN
            drop_cnt_q    <= drop_cnt_d;
`endif
        end
    end

    assign irq_out     = irq_out_q;
    assign irq_id_out  = irq_id_q;
    assign pending     = pending_q;
    assign timeout_err = timeout_err_q;
`ifdef IC_DROP_CNT_EN
    assign drop_cnt    = drop_cnt_q;
`else
    assign drop_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_ic_irq_controller.sv
module tb_ic_irq_controller;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

`ifdef IC_DROP_CNT_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_src;
    logic               mask_wr;
    logic [NUM_IRQ-1:0] mask_data;
    logic               ack;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id_out;
    logic [NUM_IRQ-1:0] pending;
    logic               timeout_err;
    logic [7:0]         drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    ic_irq_controller #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W), .TIMEOUT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .mask_wr     (mask_wr),
        .mask_data   (mask_data),
        .ack         (ack),
        .irq_out     (irq_out),
        .irq_id_out  (irq_id_out),
        .pending     (pending),
        .timeout_err (timeout_err),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge. Outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL reset_irq_out got=%0b exp=0", irq_out); end
        n_cmp++; if (irq_id_out !== 3'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", irq_id_out); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL reset_pending got=%h exp=00", pending); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr got=%0b exp=0", timeout_err); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_single();
        bit held;
        irq_src = 8'h20;
        tick();
        irq_src = 8'h00;
        n_cmp++; if (pending !== 8'h20) begin n_err++; $display("FAIL single_pending got=%h exp=20", pending); end
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL single_latency1 got=%0b exp=0", irq_out); end
        tick();
        n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL single_rise got=%0b exp=1", irq_out); end
        n_cmp++; if (irq_id_out !== 3'd5) begin n_err++; $display("FAIL single_id got=%0d exp=5", irq_id_out); end
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (irq_out !== 1'b1 || irq_id_out !== 3'd5) held = 1'b0;
        end
        n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL single_hold got=%0b exp=1", held); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL single_ack_drop got=%0b exp=0", irq_out); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL single_ack_clear got=%h exp=00", pending); end
        tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL single_stay_idle got=%0b exp=0", irq_out); end
    endtask

    task automatic test_priority();
        irq_src = 8'h44;
        tick();
        irq_src = 8'h00;
        n_cmp++; if (pending !== 8'h44) begin n_err++; $display("FAIL prio_pending got=%h exp=44", pending); end
        tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd2) begin n_err++; $display("FAIL prio_first got=%0b/%0d exp=1/2", irq_out, irq_id_out); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL prio_gap got=%0b exp=0", irq_out); end
        n_cmp++; if (pending !== 8'h40) begin n_err++; $display("FAIL prio_pending2 got=%h exp=40", pending); end
        tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd6) begin n_err++; $display("FAIL prio_second got=%0b/%0d exp=1/6", irq_out, irq_id_out); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL prio_clear got=%h exp=00", pending); end
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_data = 8'h04;
        tick();
        mask_wr = 1'b0;
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL mask_block got=%0b exp=0", irq_out); end
        n_cmp++; if (pending !== 8'h04) begin n_err++; $display("FAIL mask_pending got=%h exp=04", pending); end
        mask_wr = 1'b1; mask_data = 8'h00;
        tick();
        mask_wr = 1'b0;
        tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd2) begin n_err++; $display("FAIL mask_release got=%0b/%0d exp=1/2", irq_out, irq_id_out); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL mask_clear got=%h exp=00", pending); end
    endtask

    task automatic test_timeout();
        int high_cnt;
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick();
        // The request is now raised and will be sampled high 32 times in total.
        high_cnt = (irq_out === 1'b1) ? 1 : 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (irq_out === 1'b1) high_cnt++;
        end
        n_cmp++; if (high_cnt !== 32) begin n_err++; $display("FAIL to_high_cycles got=%0d exp=32", high_cnt); end
        tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL to_drop got=%0b exp=0", irq_out); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err got=%0b exp=1", timeout_err); end
        n_cmp++; if (pending !== 8'h02) begin n_err++; $display("FAIL to_pending_kept got=%h exp=02", pending); end
        tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd1) begin n_err++; $display("FAIL to_retry got=%0b/%0d exp=1/1", irq_out, irq_id_out); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL to_retry_clear got=%h exp=00", pending); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%0b exp=1", timeout_err); end
    endtask

    task automatic test_coalesce();
        logic [7:0] exp_drop;
        exp_drop = DROP_ON ? 8'd2 : 8'd0;
        irq_src = 8'h08; tick();
        irq_src = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd3) begin n_err++; $display("FAIL coal_req got=%0b/%0d exp=1/3", irq_out, irq_id_out); end
        irq_src = 8'h08; tick();
        irq_src = 8'h00; tick();
        irq_src = 8'h08; tick();
        irq_src = 8'h00;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL coal_clear got=%h exp=00", pending); end
        tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL coal_one_req got=%0b exp=0", irq_out); end
        n_cmp++; if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL coal_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_set_wins();
        logic [7:0] exp_drop;
        exp_drop = DROP_ON ? 8'd3 : 8'd0;
        irq_src = 8'h10; tick();
        irq_src = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd4) begin n_err++; $display("FAIL setwin_req got=%0b/%0d exp=1/4", irq_out, irq_id_out); end
        // A mask write while the request is in flight must leave it unchanged.
        mask_wr = 1'b1; mask_data = 8'h10;
        tick();
        mask_wr = 1'b0; mask_data = 8'h00;
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd4) begin n_err++; $display("FAIL setwin_mask_inflight got=%0b/%0d exp=1/4", irq_out, irq_id_out); end
        mask_wr = 1'b1;
        ack = 1'b1; irq_src = 8'h10;
        tick();
        mask_wr = 1'b0;
        ack = 1'b0; irq_src = 8'h00;
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL setwin_drop got=%0b exp=0", irq_out); end
        n_cmp++; if (pending !== 8'h10) begin n_err++; $display("FAIL setwin_pending got=%h exp=10", pending); end
        n_cmp++; if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL setwin_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
        tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id_out !== 3'd4) begin n_err++; $display("FAIL setwin_rereq got=%0b/%0d exp=1/4", irq_out, irq_id_out); end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        // The request for bit 4 from the previous task is still in flight.
        n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got=%0b exp=1", irq_out); end
        rst = 1'b1;
        #1;
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL rstmid_irq got=%0b exp=0", irq_out); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL rstmid_pending got=%h exp=00", pending); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rstmid_terr got=%0b exp=0", timeout_err); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_drop got=%0d exp=0", drop_cnt); end
        tick();
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (irq_out !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL rstmid_quiet got=%0b exp=1", quiet); end
    endtask

    initial begin
        rst       = 1'b1;
        irq_src   = '0;
        mask_wr   = 1'b0;
        mask_data = '0;
        ack       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_timeout();
        test_coalesce();
        test_set_wins();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ic_irq_controller.md
Name: ic_irq_controller

Overview:
- Interrupt controller stage directly upstream of the processor model.
- Collects NUM_IRQ synchronous interrupt sources and latches their rising edges as pending.
- Applies a software mask and picks the highest-priority unmasked pending source (lowest index wins).
- Presents the request and its ID to the processor with a hold-until-ack handshake, and recovers from missing acks with a timeout.

Parameters:
- NUM_IRQ, 8, number of interrupt sources. Fixed at 8; must equal 2**ID_W.
- ID_W, 3, width of the interrupt ID.
- TIMEOUT, 32, maximum number of REQ-state cycles to wait for ack (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- irq_src  in  NUM_IRQ  interrupt sources, synchronous to clk, rising-edge sensitive
- mask_wr  in  1  mask write strobe
- mask_data  in  NUM_IRQ  new mask value; bit=1 disables that source
- ack  in  1  one-cycle acknowledge from processor
- irq_out  out  1  interrupt request to processor
- irq_id_out  out  ID_W  ID of the in-flight request
- pending  out  NUM_IRQ  pending register, unmasked view
- timeout_err  out  1  sticky flag: a request timed out
- drop_cnt  out  8  coalesced-edge counter (see Optional Feature)

Behaviour:
Reset:
- pending, mask, source-history register, irq_out, irq_id_out, timeout_err, drop_cnt and the timeout counter all = 0.
- State = IDLE.
- A source already high at reset release registers as a rising edge on the first clock.

Edge capture:
- edge[i] = irq_src[i] & ~prev[i]; prev <= irq_src every cycle.
- edge[i] sets pending[i] at the same clock edge.
- Edge on a bit already pending: coalesced, pending stays 1.

Mask:
- mask <= mask_data on the cycle mask_wr is high.
- Masked bits stay pending but are not arbitrated.

Arbitration:
- cand = pending & ~mask.
- Winner = lowest set index of cand.
- Registered values of pending and mask are used, so an edge in cycle k can raise irq_out no earlier than after edge k+1 (2-cycle latency).

FSM (2 states):
- IDLE:
  - irq_out=0.
  - If cand!=0: irq_id_out <= winner, irq_out <= 1, counter <= 0, go REQ.
- REQ:
  - irq_out=1; irq_id_out held stable.
  - ack=1: clear pending[irq_id_out], irq_out <= 0, go IDLE.
  - No ack, counter==TIMEOUT-1: irq_out <= 0, timeout_err <= 1, pending bit kept (retried later), go IDLE.
  - Otherwise counter increments.
- irq_out is low for at least one cycle between consecutive requests, so the processor sees a fresh request from its idle state.

Simultaneous events:
- ack and timeout in the same cycle: ack wins, no error.
- New edge on irq_id_out's bit in the same cycle as the ack clear: set wins, pending stays 1.
- Mask write during REQ: in-flight request unaffected.
- ack in IDLE: ignored.
- timeout_err clears only on rst.
- rst during REQ: irq_out drops immediately (async); all state returns to reset values.

Optional Feature:
- Macro: IC_DROP_CNT_EN.
- Defined:
  - drop_cnt increments by the number of coalesced edges each cycle, i.e. edges landing on already-pending bits, including the set-wins-over-ack case.
  - Saturates at 8'hFF.
- Undefined: drop_cnt tied to 0; no counter logic is built.

Test Plan:
- Single source: pulse irq_src[5] one cycle, ack 4 cycles after irq_out rise -> irq_out high 2 cycles after the edge, irq_id_out=5, pending[5] clears on ack, irq_out low the next cycle.
- Priority: rising edges on bits 6 and 2 in the same cycle -> first request ID=2; after ack, second request ID=6 following at least one idle cycle.
- Mask: mask=8'h04, edge on bit 2 -> no irq_out, pending=8'h04; write mask=0 -> request ID=2 issued.
- Timeout: TIMEOUT=32, edge on bit 1, never ack -> irq_out drops after 32 cycles, timeout_err=1, pending[1] still 1, re-requested ID=1 after one idle cycle.
- Coalesce (IC_DROP_CNT_EN defined): three edges on bit 3 before ack -> one request only; drop_cnt=2 with the macro, 0 without it.
- Reset mid-request: assert rst while in REQ -> irq_out, pending and timeout_err = 0 immediately; no request after release unless a new edge occurs.
